// File: rtl/operand_loader_if.sv
// rtl/operand_loader_if.sv - operand bus and capture-status signal bundle for operand_loader
//
// Purpose: groups the shared operand bus, the strobes and the captured-operand
// outputs of operand_loader into one interface.
//
// Ports (interface members):
//   data_in   shared operand bus (WIDTH)
//   load      asynchronous load strobe from an external pin
//   consume   downstream has taken the operand set (synchronous level)
//   clear     synchronous abort/flush
//   A, B      captured operands (WIDTH)
//   Cantidad  captured shift amount (CNT_W)
//   valid     A, B and Cantidad form a complete set
//   state     capture FSM state for debug
//   overrun   sticky flag: a load was dropped while valid
//   cnt_ge_w  captured shift amount is >= WIDTH
//
// Modports: master drives the bus and strobes, slave is the loader itself.

interface operand_loader_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 5
);

  logic [WIDTH-1:0] data_in;
  logic             load;
  logic             consume;
  logic             clear;

  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [CNT_W-1:0] Cantidad;
  logic             valid;
  logic [1:0]       state;
  logic             overrun;
  logic             cnt_ge_w;

  modport master (
    output data_in,
    output load,
    output consume,
    output clear,
    input  A,
    input  B,
    input  Cantidad,
    input  valid,
    input  state,
    input  overrun,
    input  cnt_ge_w
  );

  modport slave (
    input  data_in,
    input  load,
    input  consume,
    input  clear,
    output A,
    output B,
    output Cantidad,
    output valid,
    output state,
    output overrun,
    output cnt_ge_w
  );

endinterface

// File: rtl/operand_loader.sv
// rtl/operand_loader.sv - three-strobe operand A/B/shift-amount capture stage for the shifter
//
// Purpose: collects operand A, operand B and the shift amount Cantidad from a
// shared bus over three load strobes, holds them stable for the combinational
// shift stage and flags when the set is complete.
//
// Ports:
//   clk    system clock, all flops rising-edge
//   rst_n  asynchronous active-low reset
//   bus    operand_loader_if.slave
//            in : data_in, load (async pin), consume, clear
//            out: A, B, Cantidad, valid, state, overrun, cnt_ge_w

module operand_loader #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 5
) (
  input logic                 clk,
  input logic                 rst_n,
  operand_loader_if.slave     bus
);

  typedef enum logic [1:0] {
    S_A = 2'b00,
    S_B = 2'b01,
    S_C = 2'b10,
    S_V = 2'b11
  } state_t;

  localparam logic [31:0] WIDTH_U = 32'(WIDTH);

  // ---------------------------------------------------------------------------
  // Strobe path: 2-flop synchronizer followed by a rising-edge detector.
  // These flops ignore clear on purpose: a load still held high across a
  // clear must not look like a fresh rising edge afterwards.
  // ---------------------------------------------------------------------------
  logic sync_ff1;
  logic sync_ff2;
  logic load_hist;
  logic load_p;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_ff1  <= 1'b0;
      sync_ff2  <= 1'b0;
      load_hist <= 1'b0;
    end else begin
      sync_ff1  <= bus.load;
      sync_ff2  <= sync_ff1;
      load_hist <= sync_ff2;
    end
  end

  // One pulse per rising edge of the synchronized strobe; the capture edge is
  // the third rising clk edge after load goes high.
  assign load_p = sync_ff2 & ~load_hist;

  // ---------------------------------------------------------------------------
  // Capture FSM and operand registers
  // ---------------------------------------------------------------------------
  state_t           state_q, state_n;
  logic [WIDTH-1:0] a_q, a_n;
  logic [WIDTH-1:0] b_q, b_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic             valid_q, valid_n;
  logic             ovr_q, ovr_n;
  logic             ge_q, ge_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_A;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
      ge_q    <= 1'b0;
    end else begin
      state_q <= state_n;
      a_q     <= a_n;
      b_q     <= b_n;
      cnt_q   <= cnt_n;
      valid_q <= valid_n;
      ovr_q   <= ovr_n;
      ge_q    <= ge_n;
    end
  end

  always_comb begin
    state_n = state_q;
    a_n     = a_q;
    b_n     = b_q;
    cnt_n   = cnt_q;
    ovr_n   = ovr_q;

    if (bus.clear) begin
      // Flush wins over everything except reset; a coincident load_p is lost.
      state_n = S_A;
      a_n     = '0;
      b_n     = '0;
      cnt_n   = '0;
      ovr_n   = 1'b0;
    end else begin
      unique case (state_q)
        S_A: begin
          if (load_p) begin
            a_n     = bus.data_in;
            state_n = S_B;
          end
        end
        S_B: begin
          if (load_p) begin
            b_n     = bus.data_in;
            state_n = S_C;
          end
        end
        S_C: begin
          if (load_p) begin
            // Upper bus bits beyond the shift-amount width are ignored.
            cnt_n   = bus.data_in[CNT_W-1:0];
            state_n = S_V;
          end
        end
        S_V: begin
          if (bus.consume) begin
            ovr_n = 1'b0;
            if (load_p) begin
              // Back-to-back sets: the strobe arriving with consume already
              // carries the next operand A.
              a_n     = bus.data_in;
              state_n = S_B;
            end else begin
              state_n = S_A;
            end
          end else if (load_p) begin
            // Set still pending downstream: drop the data, remember it.
            ovr_n = 1'b1;
          end
        end
        default: state_n = S_A;
      endcase
    end

    // valid and cnt_ge_w are registered alongside the state / amount so they
    // change on the same edge as the values they describe.
    valid_n = (state_n == S_V);
    ge_n    = ({{(32-CNT_W){1'b0}}, cnt_n} >= WIDTH_U);
  end

  assign bus.A        = a_q;
  assign bus.B        = b_q;
  assign bus.Cantidad = cnt_q;
  assign bus.valid    = valid_q;
  assign bus.state    = state_q;
  assign bus.overrun  = ovr_q;
  assign bus.cnt_ge_w = ge_q;

endmodule

// File: tb/tb_operand_loader.sv
// tb/tb_operand_loader.sv - directed self-checking bench for operand_loader

module tb_operand_loader;

  localparam int WIDTH = 8;
  localparam int CNT_W = 5;

  localparam logic [1:0] ST_A = 2'b00;
  localparam logic [1:0] ST_B = 2'b01;
  localparam logic [1:0] ST_C = 2'b10;
  localparam logic [1:0] ST_V = 2'b11;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [CNT_W-1:0] c;
    logic             ge;
  } set_t;

  logic clk;
  logic rst_n;
  int   n_assert;
  int   n_fail;
  set_t sb[$];

  operand_loader_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  operand_loader #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_A"}, 32'(bus.A), 32'h0);
    chk({tag, "_B"}, 32'(bus.B), 32'h0);
    chk({tag, "_Cantidad"}, 32'(bus.Cantidad), 32'h0);
    chk({tag, "_valid"}, 32'(bus.valid), 32'h0);
    chk({tag, "_state"}, 32'(bus.state), 32'(ST_A));
    chk({tag, "_overrun"}, 32'(bus.overrun), 32'h0);
    chk({tag, "_cnt_ge_w"}, 32'(bus.cnt_ge_w), 32'h0);
  endtask

  // Raise load with data d; checks that nothing moves on edges 1-2 and the
  // state steps to exp_state on edge 3. side=1 pairs consume, side=2 pairs
  // clear with the capture edge. load stays high for hold cycles after that.
  task automatic do_load(input logic [7:0] d, input int hold, input int side,
                         input logic [1:0] exp_state);
    logic [1:0] st0;
    @(negedge clk);
    bus.data_in = d;
    bus.load    = 1'b1;
    st0         = bus.state;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("no_capture_before_edge3", 32'(bus.state), 32'(st0));
    if (side == 1) begin
      @(negedge clk);
      bus.consume = 1'b1;
    end else if (side == 2) begin
      @(negedge clk);
      bus.clear = 1'b1;
    end
    @(posedge clk); #1;
    chk("capture_on_edge3_state", 32'(bus.state), 32'(exp_state));
    @(negedge clk);
    bus.consume = 1'b0;
    bus.clear   = 1'b0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("held_load_no_second_pulse", 32'(bus.state), 32'(exp_state));
    end
    bus.load = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic pulse_consume(input logic [1:0] exp_state);
    @(negedge clk);
    bus.consume = 1'b1;
    @(posedge clk); #1;
    chk("consume_state", 32'(bus.state), 32'(exp_state));
    @(negedge clk);
    bus.consume = 1'b0;
  endtask

  // Bounded wait for valid, then compare against the oldest expected set.
  task automatic check_set();
    set_t e;
    int   n;
    n = 0;
    while (bus.valid !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("valid_within_bound", 32'(bus.valid), 32'h1);
    if (sb.size() == 0) begin
      chk("scoreboard_nonempty", 32'h0, 32'h1);
    end else begin
      e = sb.pop_front();
      chk("set_A", 32'(bus.A), 32'(e.a));
      chk("set_B", 32'(bus.B), 32'(e.b));
      chk("set_Cantidad", 32'(bus.Cantidad), 32'(e.c));
      chk("set_cnt_ge_w", 32'(bus.cnt_ge_w), 32'(e.ge));
      chk("set_state", 32'(bus.state), 32'(ST_V));
    end
  endtask

  initial begin
    n_assert    = 0;
    n_fail      = 0;
    rst_n       = 1'b0;
    bus.data_in = '0;
    bus.load    = 1'b0;
    bus.consume = 1'b0;
    bus.clear   = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Reset in the middle of a set
    do_load(8'h5A, 1, 0, ST_B);
    do_load(8'h3C, 1, 0, ST_C);
    chk("mid_A", 32'(bus.A), 32'h5A);
    chk("mid_B", 32'(bus.B), 32'h3C);
    chk("mid_valid_not_SV", 32'(bus.valid), 32'h0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_zero("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic set
    do_load(8'hA5, 1, 0, ST_B);
    do_load(8'h0F, 1, 0, ST_C);
    sb.push_back('{a: 8'hA5, b: 8'h0F, c: 5'd3, ge: 1'b0});
    do_load(8'h03, 1, 0, ST_V);
    check_set();
    chk("basic_overrun", 32'(bus.overrun), 32'h0);

    // Overrun while valid, then consume
    do_load(8'hFF, 1, 0, ST_V);
    chk("ovr_A_kept", 32'(bus.A), 32'hA5);
    chk("ovr_B_kept", 32'(bus.B), 32'h0F);
    chk("ovr_C_kept", 32'(bus.Cantidad), 32'h03);
    chk("ovr_flag", 32'(bus.overrun), 32'h1);
    chk("ovr_valid", 32'(bus.valid), 32'h1);
    pulse_consume(ST_A);
    chk("consumed_valid", 32'(bus.valid), 32'h0);
    chk("consumed_overrun", 32'(bus.overrun), 32'h0);
    chk("consumed_A_kept", 32'(bus.A), 32'hA5);

    // Consume outside S_V is ignored
    do_load(8'h11, 1, 0, ST_B);
    pulse_consume(ST_B);
    do_load(8'h22, 1, 0, ST_C);
    sb.push_back('{a: 8'h11, b: 8'h22, c: 5'd5, ge: 1'b0});
    do_load(8'h05, 1, 0, ST_V);
    check_set();

    // Overrun, then load_p coinciding with consume
    do_load(8'h44, 1, 0, ST_V);
    chk("ovr2_flag", 32'(bus.overrun), 32'h1);
    do_load(8'h81, 1, 1, ST_B);
    chk("simul_A", 32'(bus.A), 32'h81);
    chk("simul_valid", 32'(bus.valid), 32'h0);
    chk("simul_overrun", 32'(bus.overrun), 32'h0);

    // Cantidad truncation and >= WIDTH flag
    do_load(8'h42, 1, 0, ST_C);
    sb.push_back('{a: 8'h81, b: 8'h42, c: 5'h0C, ge: 1'b1});
    do_load(8'hEC, 1, 0, ST_V);
    check_set();
    pulse_consume(ST_A);
    do_load(8'h01, 1, 0, ST_B);
    do_load(8'h02, 1, 0, ST_C);
    sb.push_back('{a: 8'h01, b: 8'h02, c: 5'h07, ge: 1'b0});
    do_load(8'h07, 1, 0, ST_V);
    check_set();
    pulse_consume(ST_A);

    // Long strobe gives one capture; clear in S_C discards a coincident pulse
    do_load(8'h33, 20, 0, ST_B);
    chk("long_A", 32'(bus.A), 32'h33);
    do_load(8'h66, 1, 0, ST_C);
    do_load(8'h99, 4, 2, ST_A);
    chk_zero("clear");

    // Fresh set after clear
    do_load(8'h10, 1, 0, ST_B);
    do_load(8'h20, 1, 0, ST_C);
    sb.push_back('{a: 8'h10, b: 8'h20, c: 5'h1F, ge: 1'b1});
    do_load(8'h1F, 1, 0, ST_V);
    check_set();
    chk("scoreboard_drained", 32'(sb.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/operand_loader.md
Name: operand_loader

Overview:
- Upstream input stage of the shifter datapath. Collects operands A and B and the shift amount Cantidad from one shared 8-bit input bus, over three strobed load events.
- Holds the three values stable for the combinational shift stage and flags when the set is complete.
- Sequential: input-strobe synchronizer with edge detection, a 4-state capture FSM, a downstream consume handshake and an overrun flag.

Parameters:
- WIDTH, 8, operand width (A, B, data_in).
- CNT_W, 5, shift-amount width (Cantidad); must satisfy CNT_W <= WIDTH.

Ports:
- clk  input  1  system clock, all flops rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- data_in  input  WIDTH  shared operand bus; sampled on the internal load pulse.
- load  input  1  load strobe from an external pin; asynchronous to clk, synchronized internally.
- consume  input  1  downstream has taken the operand set; synchronous, level-sampled.
- clear  input  1  synchronous abort/flush.
- A  output  WIDTH  captured operand A.
- B  output  WIDTH  captured operand B.
- Cantidad  output  CNT_W  captured shift amount.
- valid  output  1  A, B and Cantidad form a complete set.
- state  output  2  FSM state for debug: 00=S_A, 01=S_B, 10=S_C, 11=S_V.
- overrun  output  1  sticky flag: a load was dropped while valid.
- cnt_ge_w  output  1  registered Cantidad >= WIDTH; the shifters output 0 for these amounts.

Behaviour:
- Reset (rst_n low, asynchronous):
  - A, B, Cantidad = 0; valid = 0; overrun = 0; state = S_A.
  - Both synchronizer flops and the edge-detect history flop = 0.
- Strobe path:
  - load passes through a 2-flop synchronizer, then a rising-edge detector.
  - Output is load_p, a 1-cycle pulse.
  - Latency from load rising to register capture is 3 clk rising edges.
  - A load held high generates exactly one pulse. A load pulse shorter than one clk period may be missed; this is allowed.
- FSM:
  - S_A: on load_p, A <= data_in, go to S_B.
  - S_B: on load_p, B <= data_in, go to S_C.
  - S_C: on load_p, Cantidad <= data_in[CNT_W-1:0], go to S_V. data_in[WIDTH-1:CNT_W] is ignored.
  - S_V: valid = 1 (registered; asserted in the cycle after Cantidad capture).
    - consume: go to S_A, valid = 0 next cycle.
    - load_p without consume: data dropped, overrun <= 1, state held.
    - load_p together with consume: consume is honoured, and A <= data_in in the same edge; next state S_B, valid = 0. Back-to-back sets lose no strobe.
- consume outside S_V: ignored, no state change.
- Outputs A, B, Cantidad hold their last captured value until overwritten. They are not cleared by consume.
- clear:
  - Highest priority after reset. Next state S_A; valid = 0; overrun = 0; A, B, Cantidad = 0.
  - A load_p in the same cycle is discarded.
  - Synchronizer flops are not cleared, so a load still high does not produce a second pulse.
- overrun: cleared only by reset, by clear, or by consume accepted in S_V.
- cnt_ge_w: registered, updated with Cantidad; equals 1 when the captured value >= WIDTH (8..31 for the defaults).
- valid is 0 in every state other than S_V.

Test Plan:
- Reset mid-sequence:
  - Stimulus: load A=0x5A, B=0x3C, then assert rst_n=0 before the Cantidad load.
  - Required: all outputs 0, state=00. A fresh sequence after release works.
- Basic set:
  - Stimulus: three load strobes with data_in = 0xA5, 0x0F, 0x03.
  - Required: A=0xA5, B=0x0F, Cantidad=3, valid=1, state=11, cnt_ge_w=0. Each capture occurs exactly 3 edges after its load rises.
- Overrun then consume:
  - Stimulus: in S_V, strobe load with 0xFF.
  - Required: A, B, Cantidad unchanged, overrun=1.
  - Then pulse consume: valid=0, state=00, overrun=0.
- Simultaneous consume + load_p in S_V:
  - Stimulus: data_in=0x81 when load_p and consume coincide.
  - Required: next cycle A=0x81, state=01, valid=0, overrun=0.
- Cantidad truncation and flag:
  - Stimulus: third load with data_in=0xEC.
  - Required: Cantidad=0x0C (12), cnt_ge_w=1.
  - Then consume and a new set with amount 0x07: cnt_ge_w=0.
- Long strobe / clear:
  - Stimulus: hold load high for 20 cycles.
  - Required: exactly one capture.
  - Then assert clear while in S_C: state=00, A=B=Cantidad=0, no capture from a coincident pulse.
